// File: rtl/bf_uart_bridge.sv
// UART host link for bf_machine: RX frames feed machine_input, machine_output words go out on TX.
// Define BF_UART_PARITY_EN to add an even-parity bit to both directions.
module bf_uart_bridge #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic [WORD_SIZE-1:0] machine_input,
  output logic                 machine_input_valid,
  input  logic                 machine_input_ready,
  input  logic [WORD_SIZE-1:0] machine_output,
  input  logic                 machine_output_valid,
  output logic                 machine_output_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORD_SIZE - 1);

`ifdef BF_UART_PARITY_EN
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
`else
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
`endif

  // ---------------- RX path ----------------
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [IdxW-1:0]      rx_idx_q, rx_idx_d;
  logic [WORD_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic                 in_valid_q, in_valid_d;
  logic [WORD_SIZE-1:0] in_data_q, in_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_bad;
`ifdef BF_UART_PARITY_EN
  logic                 rx_par_err_q, rx_par_err_d;
  assign rx_bad = !rx_sync_q || rx_par_err_q;
`else
  assign rx_bad = !rx_sync_q;
`endif

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CntW'(1);
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    in_valid_d  = in_valid_q && !machine_input_ready;
    in_data_d   = in_data_q;
`ifdef BF_UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[WORD_SIZE-1:1]};
          rx_idx_d   = rx_idx_q + IdxW'(1);
`ifdef BF_UART_PARITY_EN
          if (rx_idx_q == IdxLast) rx_state_d = RxParity;
`else
          if (rx_idx_q == IdxLast) rx_state_d = RxStop;
`endif
        end
      end
`ifdef BF_UART_PARITY_EN
      RxParity: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d     = '0;
          rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
          rx_state_d   = RxStop;
        end
      end
`endif
      RxStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_state_d = RxIdle;
          // Errors win over overrun; a same-edge transfer frees the holding register.
          if (rx_bad) begin
            frame_err_d = 1'b1;
          end else if (in_valid_q && !machine_input_ready) begin
            overrun_d = 1'b1;
          end else begin
            in_valid_d = 1'b1;
            in_data_d  = rx_shift_q;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef BF_UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef BF_UART_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  assign machine_input       = in_data_q;
  assign machine_input_valid = in_valid_q;
  assign rx_frame_err        = frame_err_q;
  assign rx_overrun          = overrun_q;

  // ---------------- TX path ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [IdxW-1:0]      tx_idx_q, tx_idx_d;
  logic [WORD_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
`ifdef BF_UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    ready_d    = 1'b0;
`ifdef BF_UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        ready_d  = 1'b1;
        if (ready_q && machine_output_valid) begin
          ready_d    = 1'b0;
          tx_d       = 1'b0;
          tx_shift_d = machine_output;
          tx_state_d = TxStart;
`ifdef BF_UART_PARITY_EN
          tx_par_d = ^machine_output;
`endif
        end
      end
      TxStart: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_idx_d   = tx_idx_q + IdxW'(1);
          tx_d       = tx_shift_d[0];
          if (tx_idx_q == IdxLast) begin
`ifdef BF_UART_PARITY_EN
            tx_d       = tx_par_q;
            tx_state_d = TxParity;
`else
            tx_d       = 1'b1;
            tx_state_d = TxStop;
`endif
          end
        end
      end
`ifdef BF_UART_PARITY_EN
      TxParity: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = TxStop;
        end
      end
`endif
      TxStop: begin
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d   = '0;
          ready_d    = 1'b1;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
`ifdef BF_UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
`ifdef BF_UART_PARITY_EN
      tx_par_q <= tx_par_d;
`endif
    end
  end

  assign uart_tx              = tx_q;
  assign machine_output_ready = ready_q;

endmodule

// File: tb/tb_bf_uart_bridge.sv
// Self-checking bench for bf_uart_bridge: TX framing, RX handshake/stall, overrun, errors,
// reset mid-frame and loopback. Expected words and bits are queued as stimulus is driven.
module tb_bf_uart_bridge;
  localparam int CPB = 16;
  localparam int WS  = 8;
`ifdef BF_UART_PARITY_EN
  localparam int FB = WS + 3;
`else
  localparam int FB = WS + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_drv = 1'b1;
  logic          loop_en = 1'b0;
  logic          uart_rx, uart_tx;
  logic [WS-1:0] machine_input;
  logic          machine_input_valid;
  logic          machine_input_ready = 1'b0;
  logic [WS-1:0] machine_output = '0;
  logic          machine_output_valid = 1'b0;
  logic          machine_output_ready;
  logic          rx_frame_err, rx_overrun;

  int checks = 0;
  int passes = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  logic [WS-1:0] exp_words[$];
  logic          exp_bits[$];

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  bf_uart_bridge #(.WORD_SIZE(WS), .CLKS_PER_BIT(CPB)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_rx              (uart_rx),
    .uart_tx              (uart_tx),
    .machine_input        (machine_input),
    .machine_input_valid  (machine_input_valid),
    .machine_input_ready  (machine_input_ready),
    .machine_output       (machine_output),
    .machine_output_valid (machine_output_valid),
    .machine_output_ready (machine_output_ready),
    .rx_frame_err         (rx_frame_err),
    .rx_overrun           (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  // Drives one serial frame from a negedge; parity (if any) is always correct.
  task automatic send_frame(input logic [WS-1:0] d, input logic stop);
    logic [FB-1:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < WS; i++) bits[i+1] = d[i];
`ifdef BF_UART_PARITY_EN
    bits[WS+1] = ^d;
`endif
    bits[FB-1] = stop;
    for (int i = 0; i < FB; i++) begin
      rx_drv = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1) $display("FAIL reset_tx got %b want 1", uart_tx); else passes++;
    checks++; if (machine_input !== '0) $display("FAIL reset_min got %h want 00", machine_input); else passes++;
    checks++; if (machine_input_valid !== 1'b0) $display("FAIL reset_vld got %b want 0", machine_input_valid); else passes++;
    checks++; if (machine_output_ready !== 1'b0) $display("FAIL reset_rdy got %b want 0", machine_output_ready); else passes++;
    checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", rx_frame_err); else passes++;
    checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", rx_overrun); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (machine_output_ready !== 1'b1) $display("FAIL reset_rdy_rise got %b want 1", machine_output_ready); else passes++;
  endtask

  task automatic test_tx_word(input logic [WS-1:0] w);
    int n = 0;
    while (!machine_output_ready && n < FB * CPB + 20) begin @(negedge clk); n++; end
    checks++; if (machine_output_ready !== 1'b1) $display("FAIL tx_wait_rdy got %b want 1", machine_output_ready); else passes++;
    machine_output = w;
    machine_output_valid = 1'b1;
    @(negedge clk);
    machine_output_valid = 1'b0;
    checks++; if (machine_output_ready !== 1'b0) $display("FAIL tx_rdy_drop got %b want 0", machine_output_ready); else passes++;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < WS; i++) exp_bits.push_back(w[i]);
`ifdef BF_UART_PARITY_EN
    exp_bits.push_back(^w);
`endif
    exp_bits.push_back(1'b1);
    repeat (CPB / 2) @(negedge clk);
    for (int b = 0; b < FB; b++) begin
      logic e;
      e = exp_bits.pop_front();
      checks++; if (uart_tx !== e) $display("FAIL tx_bit%0d word %h got %b want %b", b, w, uart_tx, e); else passes++;
      if (b != FB - 1) repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2 - 1) @(negedge clk);
    checks++; if (machine_output_ready !== 1'b0) $display("FAIL tx_rdy_low_end got %b want 0", machine_output_ready); else passes++;
    @(negedge clk);
    checks++; if (machine_output_ready !== 1'b1) $display("FAIL tx_rdy_back got %b want 1", machine_output_ready); else passes++;
  endtask

  task automatic test_rx_stall;
    logic [WS-1:0] words [3];
    words[0] = 8'h03; words[1] = 8'h09; words[2] = 8'h05;
    machine_input_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      logic [WS-1:0] e;
      exp_words.push_back(words[k]);
      send_frame(words[k], 1'b1);
      while (!machine_input_valid && n < 40) begin @(negedge clk); n++; end
      for (int s = 0; s < 3; s++) begin
        checks++; if (machine_input_valid !== 1'b1) $display("FAIL stall_vld k%0d got %b want 1", k, machine_input_valid); else passes++;
        checks++; if (machine_input !== exp_words[0]) $display("FAIL stall_data k%0d got %h want %h", k, machine_input, exp_words[0]); else passes++;
        @(negedge clk);
      end
      machine_input_ready = 1'b1;
      @(negedge clk);
      machine_input_ready = 1'b0;
      e = exp_words.pop_front();
      checks++; if (machine_input !== e) $display("FAIL stall_hold k%0d got %h want %h", k, machine_input, e); else passes++;
      checks++; if (machine_input_valid !== 1'b0) $display("FAIL stall_clr k%0d got %b want 0", k, machine_input_valid); else passes++;
    end
  endtask

  task automatic test_overrun;
    int o0;
    logic [WS-1:0] e;
    o0 = ovr_cnt;
    machine_input_ready = 1'b0;
    exp_words.push_back(8'h09);
    send_frame(8'h09, 1'b1);
    send_frame(8'h05, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (ovr_cnt - o0 !== 1) $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); else passes++;
    checks++; if (machine_input_valid !== 1'b1) $display("FAIL ovr_vld got %b want 1", machine_input_valid); else passes++;
    checks++; if (machine_input !== exp_words[0]) $display("FAIL ovr_keep got %h want %h", machine_input, exp_words[0]); else passes++;
    machine_input_ready = 1'b1;
    @(negedge clk);
    machine_input_ready = 1'b0;
    e = exp_words.pop_front();
    checks++; if (machine_input !== e) $display("FAIL ovr_take got %h want %h", machine_input, e); else passes++;
    repeat (40) @(negedge clk);
    checks++; if (machine_input_valid !== 1'b0) $display("FAIL ovr_dropped got %b want 0", machine_input_valid); else passes++;
  endtask

  task automatic test_frame_err;
    int f0, o0;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0); else passes++;
    checks++; if (machine_input_valid !== 1'b0) $display("FAIL ferr_vld got %b want 0", machine_input_valid); else passes++;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); else passes++;
    checks++; if (ovr_cnt - o0 !== 0) $display("FAIL glitch_ovr got %0d want 0", ovr_cnt - o0); else passes++;
    checks++; if (machine_input_valid !== 1'b0) $display("FAIL glitch_vld got %b want 0", machine_input_valid); else passes++;
  endtask

  task automatic test_reset_mid_tx;
    int n = 0;
    while (!machine_output_ready && n < FB * CPB + 20) begin @(negedge clk); n++; end
    machine_output = 8'hFF;
    machine_output_valid = 1'b1;
    @(negedge clk);
    machine_output_valid = 1'b0;
    repeat (CPB / 2 + 4 * CPB) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) $display("FAIL rst_tx got %b want 1", uart_tx); else passes++;
    checks++; if (machine_output_ready !== 1'b0) $display("FAIL rst_rdy got %b want 0", machine_output_ready); else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (machine_output_ready !== 1'b0) $display("FAIL rst_rdy_rel got %b want 0", machine_output_ready); else passes++;
    @(negedge clk);
    checks++; if (machine_output_ready !== 1'b1) $display("FAIL rst_rdy_edge got %b want 1", machine_output_ready); else passes++;
    test_tx_word(8'h11);
  endtask

  task automatic test_loopback;
    logic [WS-1:0] words [3];
    int f0, o0;
    words[0] = 8'h00; words[1] = 8'hA5; words[2] = 8'hFF;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    loop_en = 1'b1;
    machine_input_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      logic [WS-1:0] e;
      while (!machine_output_ready && n < FB * CPB + 20) begin @(negedge clk); n++; end
      exp_words.push_back(words[k]);
      machine_output = words[k];
      machine_output_valid = 1'b1;
      @(negedge clk);
      machine_output_valid = 1'b0;
      n = 0;
      while (!machine_input_valid && n < FB * CPB + 40) begin @(negedge clk); n++; end
      checks++; if (machine_input_valid !== 1'b1) $display("FAIL loop_timeout k%0d got %b want 1", k, machine_input_valid); else passes++;
      e = exp_words.pop_front();
      checks++; if (machine_input !== e) $display("FAIL loop_data k%0d got %h want %h", k, machine_input, e); else passes++;
      @(negedge clk);
    end
    repeat (CPB * 2) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 0) $display("FAIL loop_ferr got %0d want 0", ferr_cnt - f0); else passes++;
    checks++; if (ovr_cnt - o0 !== 0) $display("FAIL loop_ovr got %0d want 0", ovr_cnt - o0); else passes++;
    loop_en = 1'b0;
    machine_input_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_word(8'h41);
    test_rx_stall();
    test_overrun();
    test_frame_err();
    test_reset_mid_tx();
    test_loopback();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
